alsu_unit: RTL and testbench

- Registered 3-bit arithmetic/logic/shift unit with a 6-bit result and a 16-bit LED error indicator.
- All control and data inputs are captured in an input register stage. The result is computed from the captured values and stored in an output register.
- Used as a standalone datapath block; the LEDs flag illegal operation requests.

---
 rtl/alsu_pkg.sv | 36 +++
 rtl/alsu_in_reg.sv | 25 ++
 rtl/alsu_unit.sv | 128 ++++++++++++
 tb/tb_alsu_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared opcode constants, widths and the captured-input bundle for the ALSU.
// The invalid-request rule lives here so the decode reads as a single condition.
package alsu_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 6;
  localparam int LED_W = 16;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_XOR    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_MULT   = 3'b011;
  localparam logic [2:0] OP_SHIFT  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;

  typedef struct packed {
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    logic [2:0]      opcode;
    logic            cin;
    logic            serial_in;
    logic            direction;
    logic            red_op_a;
    logic            red_op_b;
    logic            bypass_a;
    logic            bypass_b;
  } alsu_in_t;

  // Reductions are only meaningful for AND/XOR; 110/111 are unassigned opcodes.
  function automatic logic op_invalid(input logic [2:0] op, input logic red_req);
    logic bad_op;
    bad_op = (op == 3'b110) || (op == 3'b111);
    return bad_op || (red_req && (op != OP_AND) && (op != OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_in_reg.sv
// Input capture stage: every data/control input of the ALSU registered once,
// cleared synchronously by rst.
module alsu_in_reg
  import alsu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  alsu_in_t d,
  output alsu_in_t q
);

  alsu_in_t q_r;

  // Capture register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/alsu_unit.sv
// Registered 3-bit arithmetic/logic/shift unit: input capture stage, operation
// decode on the captured values, and a registered 6-bit result plus error LEDs.
module alsu_unit
  import alsu_pkg::*;
#(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  A,
  input  logic [IN_W-1:0]  B,
  input  logic [2:0]       opcode,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             direction,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  output logic [OUT_W-1:0] out,
  output logic [LED_W-1:0] leds
);

  localparam bit PRIO_B = (INPUT_PRIORITY == "B");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  alsu_in_t          in_s;
  alsu_in_t          q_s;
  logic              bypass_s;
  logic              red_s;
  logic              sel_b_bypass_s;
  logic              sel_b_red_s;
  logic              invalid_s;
  logic [IN_W-1:0]   red_opnd_s;
  logic [OUT_W-1:0]  op_result_s;
  logic [OUT_W-1:0]  out_next_s;
  logic [LED_W-1:0]  leds_next_s;
  logic [OUT_W-1:0]  out_r;
  logic [LED_W-1:0]  leds_r;

  assign in_s = '{a: A, b: B, opcode: opcode, cin: cin, serial_in: serial_in,
                  direction: direction, red_op_a: red_op_A, red_op_b: red_op_B,
                  bypass_a: bypass_A, bypass_b: bypass_B};

  alsu_in_reg u_in_reg (
    .clk (clk),
    .rst (rst),
    .d   (in_s),
    .q   (q_s)
  );

  // Flag arbitration and operation result from the captured inputs
  always_comb begin
    bypass_s       = q_s.bypass_a | q_s.bypass_b;
    red_s          = q_s.red_op_a | q_s.red_op_b;
    sel_b_bypass_s = (q_s.bypass_a & q_s.bypass_b) ? PRIO_B : q_s.bypass_b;
    sel_b_red_s    = (q_s.red_op_a & q_s.red_op_b) ? PRIO_B : q_s.red_op_b;
    invalid_s      = op_invalid(q_s.opcode, red_s);
    red_opnd_s     = sel_b_red_s ? q_s.b : q_s.a;
    op_result_s    = '0;
    case (q_s.opcode)
      OP_AND: begin
        if (red_s) begin
          op_result_s = {5'b00000, &red_opnd_s};
        end else begin
          op_result_s = {3'b000, q_s.a & q_s.b};
        end
      end
      OP_XOR: begin
        if (red_s) begin
          op_result_s = {5'b00000, ^red_opnd_s};
        end else begin
          op_result_s = {3'b000, q_s.a ^ q_s.b};
        end
      end
      OP_ADD:  op_result_s = {3'b000, q_s.a} + {3'b000, q_s.b} + {5'b00000, q_s.cin & FA_ON};
      OP_MULT: op_result_s = {3'b000, q_s.a} * {3'b000, q_s.b};
      // Shift and rotate work on the current result register, not on A/B
      OP_SHIFT: begin
        if (q_s.direction) begin
          op_result_s = {out_r[OUT_W-2:0], q_s.serial_in};
        end else begin
          op_result_s = {q_s.serial_in, out_r[OUT_W-1:1]};
        end
      end
      OP_ROTATE: begin
        if (q_s.direction) begin
          op_result_s = {out_r[OUT_W-2:0], out_r[OUT_W-1]};
        end else begin
          op_result_s = {out_r[0], out_r[OUT_W-1:1]};
        end
      end
      default: op_result_s = '0;
    endcase
  end

  // Bypass beats the invalid check; invalid requests blink the LEDs
  always_comb begin
    out_next_s  = '0;
    leds_next_s = '0;
    if (bypass_s) begin
      out_next_s  = sel_b_bypass_s ? {3'b000, q_s.b} : {3'b000, q_s.a};
      leds_next_s = '0;
    end else if (invalid_s) begin
      out_next_s  = '0;
      leds_next_s = ~leds_r;
    end else begin
      out_next_s  = op_result_s;
      leds_next_s = '0;
    end
  end

  // Output register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= '0;
      leds_r <= '0;
    end else begin
      out_r  <= out_next_s;
      leds_r <= leds_next_s;
    end
  end

  assign out  = out_r;
  assign leds = leds_r;

endmodule

// File: tb/tb_alsu_unit.sv
// Self-checking bench: two ALSU instances (priority A / full adder on, priority
// B / full adder off) driven in parallel and checked against a reference model.
module tb_alsu_unit;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic cin, si, dir, ra, rb, ba, bb;
  } in_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  in_t        cur = '0;
  logic [5:0]  out_a, out_b;
  logic [15:0] leds_a, leds_b;

  in_t        m_ir = '0;
  logic [5:0]  m_out_a = '0, m_out_b = '0;
  logic [15:0] m_led_a = '0, m_led_b = '0;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alsu_unit #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut_a (
    .clk(clk), .rst(rst), .A(cur.a), .B(cur.b), .opcode(cur.op), .cin(cur.cin),
    .serial_in(cur.si), .direction(cur.dir), .red_op_A(cur.ra), .red_op_B(cur.rb),
    .bypass_A(cur.ba), .bypass_B(cur.bb), .out(out_a), .leds(leds_a));

  alsu_unit #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut_b (
    .clk(clk), .rst(rst), .A(cur.a), .B(cur.b), .opcode(cur.op), .cin(cur.cin),
    .serial_in(cur.si), .direction(cur.dir), .red_op_A(cur.ra), .red_op_B(cur.rb),
    .bypass_A(cur.ba), .bypass_B(cur.bb), .out(out_b), .leds(leds_b));

  // Next {out, leds} from the captured request, using plain integer arithmetic.
  function automatic logic [21:0] ref_next(input in_t ir, input bit pb, input bit fa,
                                           input logic [5:0] o, input logic [15:0] l);
    int r, ov;
    bit use_b;
    logic [2:0] rv;
    ov = int'(o);
    if (ir.ba || ir.bb) begin
      use_b = (ir.ba && ir.bb) ? pb : ir.bb;
      r = use_b ? int'(ir.b) : int'(ir.a);
      return {6'(r), 16'h0000};
    end
    if (ir.op >= 3'd6 || ((ir.ra || ir.rb) && ir.op >= 3'd2)) return {6'd0, ~l};
    use_b = (ir.ra && ir.rb) ? pb : ir.rb;
    rv = use_b ? ir.b : ir.a;
    case (ir.op)
      3'd0: r = (ir.ra || ir.rb) ? ((rv == 3'd7) ? 1 : 0) : int'(ir.a & ir.b);
      3'd1: r = (ir.ra || ir.rb) ? ($countones(rv) % 2) : int'(ir.a ^ ir.b);
      3'd2: r = int'(ir.a) + int'(ir.b) + (fa ? int'(ir.cin) : 0);
      3'd3: r = int'(ir.a) * int'(ir.b);
      3'd4: r = ir.dir ? ((ov * 2) % 64 + int'(ir.si)) : (ov / 2 + int'(ir.si) * 32);
      3'd5: r = ir.dir ? ((ov * 2) % 64 + ov / 32) : (ov / 2 + (ov % 2) * 32);
      default: r = 0;
    endcase
    return {6'(r), 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model, then compare both instances against it.
  task automatic step();
    logic [21:0] na, nb;
    @(posedge clk);
    #1;
    if (rst) begin
      m_ir = '0; m_out_a = '0; m_out_b = '0; m_led_a = '0; m_led_b = '0;
    end else begin
      na = ref_next(m_ir, 1'b0, 1'b1, m_out_a, m_led_a);
      nb = ref_next(m_ir, 1'b1, 1'b0, m_out_b, m_led_b);
      {m_out_a, m_led_a} = na;
      {m_out_b, m_led_b} = nb;
      m_ir = cur;
    end
    chk("model_out_a", {10'd0, out_a}, {10'd0, m_out_a});
    chk("model_leds_a", leds_a, m_led_a);
    chk("model_out_b", {10'd0, out_b}, {10'd0, m_out_b});
    chk("model_leds_b", leds_b, m_led_b);
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur = in_t'($urandom);
      step();
      chk("rst_out_a", {10'd0, out_a}, 16'd0);
      chk("rst_leds_a", leds_a, 16'd0);
      chk("rst_out_b", {10'd0, out_b}, 16'd0);
    end
    rst = 1'b0;

    // Bypass overrides an invalid opcode
    cur = '0; cur.a = 3'd5; cur.op = 3'b111; cur.ba = 1'b1;
    step(); step();
    chk("bypass_a_out", {10'd0, out_a}, 16'd5);
    chk("bypass_a_leds", leds_a, 16'd0);

    cur = '0; cur.a = 3'd3; cur.b = 3'd6; cur.ba = 1'b1; cur.bb = 1'b1;
    step(); step();
    chk("bypass_both_prioA", {10'd0, out_a}, 16'd3);
    chk("bypass_both_prioB", {10'd0, out_b}, 16'd6);

    // Arithmetic
    cur = '0; cur.a = 3'd7; cur.b = 3'd7; cur.cin = 1'b1; cur.op = 3'b010;
    step(); step();
    chk("add_full", {10'd0, out_a}, 16'd15);
    chk("add_half", {10'd0, out_b}, 16'd14);
    cur.op = 3'b011;
    step(); step();
    chk("mult_a", {10'd0, out_a}, 16'd49);
    chk("mult_b", {10'd0, out_b}, 16'd49);

    // Reductions
    cur = '0; cur.a = 3'b111; cur.b = 3'b010; cur.ra = 1'b1; cur.op = 3'b000;
    step(); step();
    chk("red_and_A", {10'd0, out_a}, 16'd1);
    cur.ra = 1'b0; cur.rb = 1'b1; cur.op = 3'b001;
    step(); step();
    chk("red_xor_B", {10'd0, out_b}, 16'd1);
    cur.ra = 1'b1; cur.rb = 1'b1; cur.op = 3'b000;
    step(); step();
    chk("red_both_prioA", {10'd0, out_a}, 16'd1);
    chk("red_both_prioB", {10'd0, out_b}, 16'd0);

    // Shift/rotate: 000011 -> rotate right -> 100001, then shift/rotate chain
    cur = '0; cur.a = 3'd3; cur.ba = 1'b1;
    step(); step();
    cur = '0; cur.op = 3'b101; cur.dir = 1'b0;
    step();
    cur = '0; cur.op = 3'b100; cur.dir = 1'b1; cur.si = 1'b0;
    step();
    chk("preload", {10'd0, out_a}, 16'h0021);
    cur = '0; cur.op = 3'b101; cur.dir = 1'b0;
    step();
    chk("shift_left", {10'd0, out_a}, 16'h0002);
    step();
    chk("rot_right1", {10'd0, out_a}, 16'h0001);
    step();
    chk("rot_right2", {10'd0, out_b}, 16'h0020);

    // Invalid opcode blinks the LEDs
    cur = '0; cur.op = 3'b110;
    step(); step();
    chk("inv_leds1", leds_a, 16'hFFFF);
    chk("inv_out1", {10'd0, out_a}, 16'd0);
    step();
    chk("inv_leds2", leds_a, 16'h0000);
    step();
    chk("inv_leds3", leds_b, 16'hFFFF);
    cur = '0; cur.ra = 1'b1; cur.op = 3'b010;
    step();
    chk("inv_red_leds1", leds_a, 16'h0000);
    step();
    chk("inv_red_leds2", leds_a, 16'hFFFF);
    cur = '0; cur.a = 3'd7; cur.b = 3'd5; cur.op = 3'b000;
    step(); step();
    chk("recover_leds", leds_a, 16'h0000);
    chk("recover_out", {10'd0, out_a}, 16'd5);

    // Reset while blinking
    cur = '0; cur.op = 3'b111;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("midrst_leds", leds_a, 16'd0);
    chk("midrst_out", {10'd0, out_b}, 16'd0);
    rst = 1'b0;
    step();
    chk("post_rst_leds", leds_a, 16'd0);
    step();
    chk("post_rst_blink", leds_a, 16'hFFFF);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cur = in_t'($urandom);
      cur.ba = ($urandom_range(0, 7) == 0);
      cur.bb = ($urandom_range(0, 7) == 0);
      cur.ra = ($urandom_range(0, 3) == 0);
      cur.rb = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
